sumador_serial_ctrl: RTL
========================

SUMADOR_SERIAL_CTRL -- requirements
Module: sumador_serial_ctrl

Interface
REQ-001 Parameter: ANCHO, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inicio  input  1  start request; sampled on each rising edge.
REQ-005 A  input  ANCHO  operand A; sampled only on an accepted start.
REQ-006 B  input  ANCHO  operand B; sampled only on an accepted start.
REQ-007 AcarreoEntrada  input  1  carry-in; sampled only on an accepted start.
REQ-008 ocupado  output  1  high while the serial addition is in progress.
REQ-009 listo  output  1  one-cycle pulse; result valid.
REQ-010 Resultado  output  ANCHO  sum A+B+AcarreoEntrada, modulo 2^ANCHO.
REQ-011 AcarreoSalida  output  1  final carry-out (bit ANCHO of the full sum).

Function
REQ-012 The block SHALL time-share one 1-bit full-adder cell across all ANCHO bits, processing LSB first, one bit per clock.
REQ-013 FSM states SHALL be REPOSO (idle), SUMA (bit-serial add) and FIN (result pulse).
REQ-014 REPOSO or FIN with inicio=1 at an edge SHALL accept: latch A, B, carry register <= AcarreoEntrada, bit counter <= 0, next state SUMA.
REQ-015 REPOSO with inicio=0 SHALL stay in REPOSO; FIN with inicio=0 SHALL go to REPOSO.
REQ-016 Each SUMA edge SHALL shift the full-adder sum bit into the result register MSB (right shift), shift both operand registers right by one, load carry register with cell carry-out, increment counter.
REQ-017 SUMA SHALL last exactly ANCHO edges; on the edge where counter = ANCHO-1, next state SHALL be FIN.
REQ-018 Latency: listo SHALL be high exactly ANCHO edges after the accepting edge, for exactly one cycle (the FIN cycle).
REQ-019 ocupado SHALL be 1 in SUMA only; 0 in REPOSO and FIN.
REQ-020 inicio while in SUMA SHALL be ignored; operand registers and counter unaffected.
REQ-021 Resultado and AcarreoSalida SHALL update only on the transition into FIN and SHALL hold until the next FIN; intermediate shift state SHALL NOT be visible on the outputs.
REQ-022 A, B, AcarreoEntrada changes after the accepting edge SHALL have no effect on the current operation.
REQ-023 Back-to-back: inicio=1 in FIN SHALL start a new operation with no idle cycle; listo SHALL NOT be high two consecutive cycles.
REQ-024 Overflow: carry beyond bit ANCHO-1 SHALL appear only on AcarreoSalida; Resultado wraps modulo 2^ANCHO.

Reset
REQ-025 rst=1 at an edge SHALL force state REPOSO, counter 0, operand, result and carry registers 0.
REQ-026 Output values while/after reset: ocupado=0, listo=0, Resultado=0, AcarreoSalida=0.
REQ-027 rst SHALL take priority over inicio in the same cycle; reset mid-SUMA SHALL abort with no listo pulse.

Structure
REQ-028 Shared package sumador_pkg SHALL hold the state encoding (REPOSO=2'd0, SUMA=2'd1, FIN=2'd2) and default ANCHO constant.
REQ-029 Counter width SHALL be $clog2(ANCHO) bits, derived in the module.
REQ-030 The bit datapath SHALL be one instance of the existing full-adder module Sumador_Completo (X, Y, AcarreoEntrada, AcarreoSalida, Salida); no other sub-module.
REQ-031 Unused state encoding 2'd3 SHALL return to REPOSO on the next edge.

Verification (ANCHO=8)
REQ-032 A=8'h5A, B=8'h33, AcarreoEntrada=0, inicio 1 cycle -> Resultado=8'h8D, AcarreoSalida=0, listo exactly 8 edges after the accepting edge, ocupado high 8 cycles.
REQ-033 A=8'hFF, B=8'h01, AcarreoEntrada=0 -> Resultado=8'h00, AcarreoSalida=1; A=8'hFF, B=8'hFF, AcarreoEntrada=1 -> Resultado=8'hFF, AcarreoSalida=1.
REQ-034 inicio re-asserted and A/B changed to 8'h00 during SUMA of 8'h10+8'h20 -> Resultado=8'h30, single listo pulse, no second operation.
REQ-035 rst asserted on 4th SUMA cycle of 8'hAA+8'h55 -> next cycle ocupado=0, listo=0, Resultado=8'h00; no listo pulse; subsequent 8'h01+8'h01 yields 8'h02.
REQ-036 inicio held high continuously with 8'h01+8'h02 -> listo pulses every 9 cycles, Resultado=8'h03 each time, ocupado low only in FIN cycles.
REQ-037 Exhaustive sweep ANCHO=4 over all A, B, AcarreoEntrada (512 cases) -> {AcarreoSalida,Resultado} equals A+B+AcarreoEntrada for every case.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared constants for the serial adder: state encoding
// and default operand width.
package sumador_pkg;

  localparam int ANCHO_DEF = 8;

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] SUMA   = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

endpackage

// File: rtl/sumador_serial_ctrl_completo.sv
// Sumador_Completo: 1-bit full adder cell.
// Ports: X, Y, AcarreoEntrada in; Salida, AcarreoSalida out.
module Sumador_Completo (
  input  logic X,
  input  logic Y,
  input  logic AcarreoEntrada,
  output logic AcarreoSalida,
  output logic Salida
);

  logic p;

  assign p             = X ^ Y;
  assign Salida        = p ^ AcarreoEntrada;
  assign AcarreoSalida = (X & Y) | (AcarreoEntrada & p);

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high), inicio, A, B, AcarreoEntrada in;
// ocupado, listo, Resultado, AcarreoSalida out.
module sumador_serial_ctrl
  import sumador_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic             AcarreoEntrada,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] Resultado,
  output logic             AcarreoSalida
);

  localparam int CW = $clog2(ANCHO);
  localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

  logic [1:0]       estado;
  logic [ANCHO-1:0] reg_a;
  logic [ANCHO-1:0] reg_b;
  logic [ANCHO-2:0] reg_s;
  logic             acarreo;
  logic [CW-1:0]    cuenta;
  logic             bit_s;
  logic             bit_c;
  logic [ANCHO-1:0] res_sig;

  Sumador_Completo u_fa (
    .X              (reg_a[0]),
    .Y              (reg_b[0]),
    .AcarreoEntrada (acarreo),
    .AcarreoSalida  (bit_c),
    .Salida         (bit_s)
  );

  // Sum bit enters at the MSB; after ANCHO shifts the
  // first bit computed has reached bit 0.
  assign res_sig = {bit_s, reg_s};

  assign ocupado = (estado == SUMA);
  assign listo   = (estado == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= REPOSO;
      reg_a         <= '0;
      reg_b         <= '0;
      reg_s         <= '0;
      acarreo       <= 1'b0;
      cuenta        <= '0;
      Resultado     <= '0;
      AcarreoSalida <= 1'b0;
    end else begin
      case (estado)
        REPOSO, FIN: begin
          if (inicio) begin
            reg_a   <= A;
            reg_b   <= B;
            acarreo <= AcarreoEntrada;
            cuenta  <= '0;
            estado  <= SUMA;
          end else begin
            estado  <= REPOSO;
          end
        end
        SUMA: begin
          reg_s   <= res_sig[ANCHO-1:1];
          reg_a   <= reg_a >> 1;
          reg_b   <= reg_b >> 1;
          acarreo <= bit_c;
          cuenta  <= cuenta + 1'b1;
          // Outputs only change here so partial sums stay hidden.
          if (cuenta == ULTIMO) begin
            estado        <= FIN;
            Resultado     <= res_sig;
            AcarreoSalida <= bit_c;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
